// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, ALU operand/result bus, writeback
// report and illegal-instruction status for the alu_issue stage.
// The "master" modport is the issue stage itself; "slave" is its environment
// (fetch side, ALU and observers).
interface alu_issue_if #(
  parameter int COUNT_W = 16
);
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [2:0]         alu_operation;
  logic               alu_control;
  logic               alu_lt;
  logic               alu_ltu;
  logic [31:0]        alu_result;
  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               illegal;
  logic [COUNT_W-1:0] illegal_count;

  modport master (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_a, alu_b, alu_operation, alu_control,
           alu_lt, alu_ltu, wb_valid, wb_rd, wb_data, illegal, illegal_count
  );

  modport slave (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_a, alu_b, alu_operation, alu_control,
           alu_lt, alu_ltu, wb_valid, wb_rd, wb_data, illegal, illegal_count
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: single-issue RV32I OP / OP-IMM decode and operand stage.
// Decodes an accepted instruction, reads rs1/rs2 from a 32x32 register file,
// registers the ALU inputs (plus signed/unsigned less-than flags) and writes
// the combinational ALU result back to rd one cycle later.
// Optional feature macro: ALU_ISSUE_FORWARD_EN
//   defined   - a read of the register still in flight is taken from
//               alu_result; instr_ready is always 1.
//   undefined - such a read stalls instr_ready low for one cycle until the
//               write has landed in the register file.
module alu_issue #(
  parameter int COUNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_issue_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign imm    = bus.instr[31:20];

  logic is_op;
  logic is_op_imm;
  logic legal;
  logic dec_control;

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);

  // Execute-stage state
  logic              ex_valid;
  logic [4:0]        ex_rd;
  logic [31:0]       alu_a_q;
  logic [31:0]       alu_b_q;
  logic [2:0]        alu_op_q;
  logic              alu_ctrl_q;
  logic              alu_lt_q;
  logic              alu_ltu_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;
  logic              illegal_q;
  logic [COUNT_W-1:0] ill_cnt_q;

  logic [31:0] rf [32];

  // Legality check: funct7 (imm[11:5]) constraints per opcode and funct3
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    legal = 1'b0;
    if (is_op) begin
      legal = (imm[11:5] == F7_ZERO) ||
              ((imm[11:5] == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_op_imm) begin
      case (funct3)
        3'b001:  legal = (imm[11:5] == F7_ZERO);
        3'b101:  legal = (imm[11:5] == F7_ZERO) || (imm[11:5] == F7_ALT);
        default: legal = 1'b1;
      endcase
    end
  end

  // instr[30] selects sub/sra for OP, but only sra for the OP-IMM shifts
  assign dec_control = is_op ? bus.instr[30] : ((funct3 == 3'b101) && bus.instr[30]);

  // Register file reads; x0 is hard-wired to zero
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // A source matches the destination whose write is still pending this cycle
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = ex_valid && (ex_rd != 5'd0) && (rs1 == ex_rd);
  assign fwd_b = ex_valid && (ex_rd != 5'd0) && is_op && (rs2 == ex_rd);

  logic [31:0] op_a;
  logic [31:0] op_rs2;
  logic [31:0] op_b;
  logic        ready;

`ifdef ALU_ISSUE_FORWARD_EN
  assign op_a   = fwd_a ? bus.alu_result : rs1_val;
  assign op_rs2 = fwd_b ? bus.alu_result : rs2_val;
  assign ready  = 1'b1;
`else
  assign op_a   = rs1_val;
  assign op_rs2 = rs2_val;
  assign ready  = !(fwd_a || fwd_b);
`endif

  assign op_b = is_op ? op_rs2 : {{20{imm[11]}}, imm};

  logic accept;
  assign accept = bus.instr_valid && ready;

  // Execute stage: latch ALU inputs on accept; ex_valid marks a pending write
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rd      <= 5'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_op_q   <= 3'd0;
      alu_ctrl_q <= 1'b0;
      alu_lt_q   <= 1'b0;
      alu_ltu_q  <= 1'b0;
    end else if (accept) begin
      ex_valid   <= legal;
      ex_rd      <= rd;
      alu_a_q    <= op_a;
      alu_b_q    <= op_b;
      alu_op_q   <= funct3;
      alu_ctrl_q <= dec_control;
      alu_lt_q   <= ($signed(op_a) < $signed(op_b));
      alu_ltu_q  <= (op_a < op_b);
    end else begin
      ex_valid <= 1'b0;
    end
  end

  // Writeback: commit alu_result to rd and report it; x0 writes are dropped
  // NOTE: the register file is reset explicitly because reads after reset
  // must return 0; this makes it flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
    end else if (ex_valid && (ex_rd != 5'd0)) begin
      rf[ex_rd]  <= bus.alu_result;
      wb_valid_q <= 1'b1;
      wb_rd_q    <= ex_rd;
      wb_data_q  <= bus.alu_result;
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

  // Illegal-instruction pulse and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && !legal && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + COUNT_W'(1);
    end
  end

  assign bus.instr_ready   = ready;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_operation = alu_op_q;
  assign bus.alu_control   = alu_ctrl_q;
  assign bus.alu_lt        = alu_lt_q;
  assign bus.alu_ltu       = alu_ltu_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.illegal       = illegal_q;
  assign bus.illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue with a behavioural RV32I
// ALU closing the loop on alu_result. Expected values are hand-computed.
// Builds with or without ALU_ISSUE_FORWARD_EN; only the stall count differs.
module tb_alu_issue;

  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_if #(.COUNT_W(CW)) bus ();

  alu_issue #(.COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU fed by the registered alu_* outputs
  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_operation)
      3'b000: bus.alu_result = bus.alu_control ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      3'b010: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      3'b011: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      3'b100: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b101: bus.alu_result = bus.alu_control ? 32'($signed(bus.alu_a) >>> bus.alu_b[4:0])
                                               : bus.alu_a >> bus.alu_b[4:0];
      3'b110: bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = bus.alu_a & bus.alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and hold it until accepted; checks the stall count
  task automatic send(input logic [31:0] word, input int exp_stalls, input string tag);
    int stalls;
    stalls = 0;
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    #1;
    while (!bus.instr_ready && stalls < 4) begin
      step();
      stalls++;
    end
    check({tag, "_stalls"}, stalls, exp_stalls);
    step();
    bus.instr_valid = 1'b0;
  endtask

`ifdef ALU_ISSUE_FORWARD_EN
  localparam int HAZ_STALLS = 0;
`else
  localparam int HAZ_STALLS = 1;
`endif

  logic [31:0] bad_tab [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bad_tab[0] = 32'h0000007F;  // unknown opcode
    bad_tab[1] = 32'h02001093;  // SLLI x1 with imm[11:5]=0000001
    bad_tab[2] = 32'h60005093;  // SRxI with imm[11:5]=0110000
    bad_tab[3] = 32'h40001033;  // OP funct7=0100000 funct3=001
    bad_tab[4] = 32'h40002033;  // OP funct7=0100000 funct3=010
    bad_tab[5] = 32'h00000003;  // LOAD opcode
    bad_tab[6] = 32'h04000033;  // OP funct7=0000010
    bad_tab[7] = 32'h0000006F;  // JAL opcode

    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    #12 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_ready", bus.instr_ready, 1);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_count", bus.illegal_count, 0);

    // ADDI x1,x0,5
    send(32'h00500093, 0, "addi_x1");
    check("addi_x1_a", bus.alu_a, 0);
    check("addi_x1_b", bus.alu_b, 5);
    check("addi_x1_op", bus.alu_operation, 3'b000);
    check("addi_x1_ctl", bus.alu_control, 0);
    step();
    check("addi_x1_wbv", bus.wb_valid, 1);
    check("addi_x1_wbrd", bus.wb_rd, 1);
    check("addi_x1_wbd", bus.wb_data, 5);

    // ADDI x2,x0,-3 then back-to-back SUB x3,x1,x2 (hazard on rs2)
    send(32'hFFD00113, 0, "addi_x2");
    check("addi_x2_b", bus.alu_b, 32'hFFFFFFFD);
    send(32'h402081B3, HAZ_STALLS, "sub_x3");
    check("sub_a", bus.alu_a, 5);
    check("sub_b", bus.alu_b, 32'hFFFFFFFD);
    check("sub_ctl", bus.alu_control, 1);
    step();
    check("sub_wbv", bus.wb_valid, 1);
    check("sub_wbrd", bus.wb_rd, 3);
    check("sub_wbd", bus.wb_data, 8);

    // SLT x4,x2,x1: -3 < 5 signed, 0xFFFFFFFD > 5 unsigned
    send(32'h00112233, 0, "slt");
    check("slt_lt", bus.alu_lt, 1);
    check("slt_ltu", bus.alu_ltu, 0);
    step();
    check("slt_wbd", bus.wb_data, 1);

    // SRAI x5,x2,1
    send(32'h40115293, 0, "srai");
    check("srai_op", bus.alu_operation, 3'b101);
    check("srai_ctl", bus.alu_control, 1);
    check("srai_shamt", bus.alu_b[4:0], 1);
    step();
    check("srai_wbd", bus.wb_data, 32'hFFFFFFFE);

    // MUL encoding is illegal
    send(32'h02208033, 0, "mul");
    check("mul_illegal", bus.illegal, 1);
    check("mul_count", bus.illegal_count, 1);
    step();
    check("mul_pulse_end", bus.illegal, 0);
    check("mul_wbv", bus.wb_valid, 0);

    // ADDI x0,x0,7 then ADD x7,x0,x0: dropped write, no forward from x0
    send(32'h00700013, 0, "addi_x0");
    check("addi_x0_b", bus.alu_b, 7);
    send(32'h000003B3, 0, "add_x7");
    check("addi_x0_wbv", bus.wb_valid, 0);
    check("add_x7_a", bus.alu_a, 0);
    step();
    check("add_x7_wbv", bus.wb_valid, 1);
    check("add_x7_wbrd", bus.wb_rd, 7);
    check("add_x7_wbd", bus.wb_data, 0);

    // Illegal counter saturates at all-ones
    for (int i = 0; i < 8; i++) begin
      send(bad_tab[i], 0, "bad");
      check("bad_illegal", bus.illegal, 1);
      check("bad_count", bus.illegal_count, (i + 2 > 7) ? 7 : i + 2);
    end
    step();
    check("sat_count", bus.illegal_count, 7);
    check("sat_pulse_end", bus.illegal, 0);
    check("sat_wbv", bus.wb_valid, 0);

    // x1 untouched by the illegal SLLI x1: ADD x9,x1,x0
    send(32'h000084B3, 0, "add_x9");
    check("add_x9_a", bus.alu_a, 5);
    step();
    check("add_x9_wbd", bus.wb_data, 5);

    // Reset in the cycle after accepting ADDI x6,x0,9 drops the write
    send(32'h00900313, 0, "addi_x6");
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", bus.alu_a, 0);
    check("mid_rst_b", bus.alu_b, 0);
    check("mid_rst_op", bus.alu_operation, 0);
    check("mid_rst_wbv", bus.wb_valid, 0);
    check("mid_rst_wbd", bus.wb_data, 0);
    check("mid_rst_count", bus.illegal_count, 0);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_ready", bus.instr_ready, 1);
    check("post_rst_wbv", bus.wb_valid, 0);
    send(32'h000303B3, 0, "add_x7_x6");
    check("x6_read_a", bus.alu_a, 0);
    step();
    check("x6_wbv", bus.wb_valid, 1);
    check("x6_wbd", bus.wb_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
